// File: rtl/sccb_master.sv
// SCCB master: 3-phase register writes and 2-phase-write + 2-phase-read register reads.
// SIO_C comes from an internal divider; SIO_D is a split out/oe/in triple for an external IOBUF.
module sccb_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [7:0]  SLAVE_ADDR = 8'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] reg_address,
  input  logic [7:0] reg_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       sio_c,
  output logic       sio_d_out,
  output logic       sio_d_oe,
  input  logic       sio_d_in
);

  localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FRAME_W = 27;
  localparam int unsigned CNT_W   = 5;

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("sccb_master: CLK_DIV must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_LOW     = 3'd2,
    S_HIGH    = 3'd3,
    S_STOP_LO = 3'd4,
    S_STOP_HI = 3'd5,
    S_GAP1    = 3'd6,
    S_GAP2    = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic               tick;
  logic               accept;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   nxt_bit;
  logic               is_last;
  logic               rw_q, rw_d;
  logic               second_q, second_d;
  logic [7:0]         rd_sh_q, rd_sh_d;
  logic [7:0]         rd_data_d;
  logic               sio_c_d, sio_d_out_d, sio_d_oe_d, busy_d, done_d;

  // Master releases SIO_D on don't-care bits and, in the second read phase, on the data byte.
  function automatic logic bit_oe(input logic rd_phase, input logic [CNT_W-1:0] idx);
    if (rd_phase) return !((idx >= 5'd8) && (idx <= 5'd16));
    return !((idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26));
  endfunction

  assign tick    = (state_q != S_IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
  assign accept  = (state_q == S_IDLE) && start && !done;
  assign nxt_bit = bit_q + 5'd1;
  assign is_last = (bit_q == (rw_q ? 5'd17 : 5'd26));

  // T-tick divider, parked at zero while idle
  always_ff @(posedge clk) begin
    if (rst || (state_q == S_IDLE) || tick) div_q <= '0;
    else                                   div_q <= div_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_START;
      S_START:   if (tick) state_d = S_LOW;
      S_LOW:     if (tick) state_d = S_HIGH;
      S_HIGH:    if (tick) state_d = is_last ? S_STOP_LO : S_LOW;
      S_STOP_LO: if (tick) state_d = S_STOP_HI;
      S_STOP_HI: if (tick) state_d = (rw_q && !second_q) ? S_GAP1 : S_IDLE;
      S_GAP1:    if (tick) state_d = S_GAP2;
      S_GAP2:    if (tick) state_d = S_START;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the bus pins, handshake and shift registers; all change on ticks or accept
  always_comb begin
    sh_d        = sh_q;
    bit_d       = bit_q;
    rw_d        = rw_q;
    second_d    = second_q;
    rd_sh_d     = rd_sh_q;
    rd_data_d   = rd_data;
    sio_c_d     = sio_c;
    sio_d_out_d = sio_d_out;
    sio_d_oe_d  = sio_d_oe;
    busy_d      = busy;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sh_d        = {SLAVE_ADDR, 1'b1, reg_address, 1'b1, reg_data, 1'b1};
          rw_d        = rw;
          second_d    = 1'b0;
          bit_d       = '0;
          busy_d      = 1'b1;
          sio_c_d     = 1'b1;
          sio_d_out_d = 1'b0;
          sio_d_oe_d  = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          sio_c_d     = 1'b0;
          sio_d_out_d = sh_q[FRAME_W-1];
          sio_d_oe_d  = bit_oe(second_q, bit_q);
          sh_d        = {sh_q[FRAME_W-2:0], 1'b1};
        end
      end
      S_LOW: begin
        if (tick) begin
          sio_c_d = 1'b1;
          if (second_q && (bit_q >= 5'd9) && (bit_q <= 5'd16))
            rd_sh_d = {rd_sh_q[6:0], sio_d_in};
        end
      end
      S_HIGH: begin
        if (tick) begin
          sio_c_d = 1'b0;
          if (is_last) begin
            sio_d_out_d = 1'b0;
            sio_d_oe_d  = 1'b1;
          end else begin
            bit_d       = nxt_bit;
            sio_d_out_d = sh_q[FRAME_W-1];
            sio_d_oe_d  = bit_oe(second_q, nxt_bit);
            sh_d        = {sh_q[FRAME_W-2:0], 1'b1};
          end
        end
      end
      S_STOP_LO: begin
        if (tick) sio_c_d = 1'b1;
      end
      S_STOP_HI: begin
        if (tick) begin
          sio_d_out_d = 1'b1;
          if (rw_q && !second_q) begin
            // Second phase: read ID, don't-care, eight released bits, NA=1
            second_d = 1'b1;
            bit_d    = '0;
            sh_d     = {SLAVE_ADDR | 8'h01, 1'b1, 8'hFF, 1'b1, 9'h1FF};
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
            if (rw_q) rd_data_d = rd_sh_q;
          end
        end
      end
      S_GAP2: begin
        if (tick) sio_d_out_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q      <= '0;
      bit_q     <= '0;
      rw_q      <= 1'b0;
      second_q  <= 1'b0;
      rd_sh_q   <= '0;
      rd_data   <= '0;
      sio_c     <= 1'b1;
      sio_d_out <= 1'b1;
      sio_d_oe  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      second_q  <= second_d;
      rd_sh_q   <= rd_sh_d;
      rd_data   <= rd_data_d;
      sio_c     <= sio_c_d;
      sio_d_out <= sio_d_out_d;
      sio_d_oe  <= sio_d_oe_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
